toggle_counter: RTL and testbench

TOGGLE_COUNTER -- requirements
Module: toggle_counter

---
 rtl/toggle_counter.sv | 92 +++++++++
 tb/tb_toggle_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/toggle_counter.sv
// Loadable register with hold, per-bit toggle, and modulo up/down count modes.
// q_n is a separate flop bank so both polarities come straight off registers.
module toggle_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

  // Terminal value kept one bit wider so MODULUS = 2^WIDTH is representable.
  localparam logic [WIDTH:0] TOP = (WIDTH + 1)'(MODULUS - 1);

  mode_e          mode_sel;
  logic [WIDTH:0] cnt_ext;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] cnt_n_q;
  logic           wrap_d, wrap_q;

  assign mode_sel = mode_e'(mode);
  assign cnt_ext  = {1'b0, cnt_q};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/case leaves a variable unassigned and infers a latch.
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = din;
    end else if (en) begin
      unique case (mode_sel)
        MODE_HOLD:   cnt_d = cnt_q;
        MODE_TOGGLE: cnt_d = cnt_q ^ t;
        MODE_UP: begin
          if (cnt_ext >= TOP) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          // Zero and out-of-range values both land on the terminal value.
          if (cnt_ext == '0 || cnt_ext > TOP) begin
            cnt_d  = TOP[WIDTH-1:0];
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q   <= '0;
      cnt_n_q <= '1;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cnt_n_q <= ~cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign q_n  = cnt_n_q;
  assign wrap = wrap_q;
  assign tc   = ((mode_sel == MODE_UP)   && (cnt_ext >= TOP)) ||
                ((mode_sel == MODE_DOWN) && (cnt_q == '0));

endmodule

// File: tb/tb_toggle_counter.sv
// Directed bench for toggle_counter: an integer model is compared every cycle,
// and hand-computed literals pin the model at the interesting points.
module tb_toggle_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
  localparam int MASK    = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] t = '0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] q, q_n;
  logic             tc, wrap;

  int  n_total = 0;
  int  n_pass  = 0;
  int  m_q     = 0;
  bit  m_wrap  = 1'b0;
  bit  m_valid = 1'b0;

  toggle_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .t    (t),
    .load (load),
    .din  (din),
    .q    (q),
    .q_n  (q_n),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock: drive inputs, advance the model at the edge, return after the
  // negedge compare has run.
  task automatic step(input logic r, input logic ld, input logic e, input logic [1:0] m,
                      input logic [WIDTH-1:0] tt, input logic [WIDTH-1:0] dd);
    rst = r; load = ld; en = e; mode = m; t = tt; din = dd;
    @(posedge clk);
    if (r) begin
      m_q = 0; m_wrap = 0; m_valid = 1'b1;
    end else if (ld) begin
      m_q = int'(dd); m_wrap = 0;
    end else if (e && m == 2'b01) begin
      m_q = m_q ^ int'(tt); m_wrap = 0;
    end else if (e && m == 2'b10) begin
      m_wrap = (m_q + 1 >= MODULUS);
      m_q    = m_wrap ? 0 : m_q + 1;
    end else if (e && m == 2'b11) begin
      m_wrap = (m_q == 0) || (m_q >= MODULUS);
      m_q    = m_wrap ? MODULUS - 1 : m_q - 1;
    end else begin
      m_wrap = 0;
    end
    @(negedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q",    32'(q),    32'(m_q));
      check("model_q_n",  32'(q_n),  32'((~m_q) & MASK));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
      check("model_tc",   32'(tc),
            32'(((mode == 2'b10) && (m_q >= MODULUS - 1)) || ((mode == 2'b11) && (m_q == 0))));
    end
  end

  initial begin
    int exp_up[12];
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    // Reset
    step(1, 0, 0, 2'b00, 4'h0, 4'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_n", 32'(q_n), 32'hF);
    check("rst_wrap", 32'(wrap), 32'h0);

    // Up-count wrap
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 2'b10, 4'h0, 4'h0);
      check("up_q", 32'(q), 32'(exp_up[i]));
      check("up_wrap", 32'(wrap), 32'(exp_up[i] == 0));
      check("up_tc", 32'(tc), 32'(exp_up[i] == 9));
    end

    // Down-count from 0; reset overrides en/mode
    step(1, 0, 1, 2'b11, 4'h0, 4'h0);
    check("dn_tc_at_0", 32'(tc), 32'h1);
    step(0, 0, 1, 2'b11, 4'h0, 4'h0);
    check("dn_q9", 32'(q), 32'h9);
    check("dn_wrap9", 32'(wrap), 32'h1);
    step(0, 0, 1, 2'b11, 4'h0, 4'h0);
    check("dn_q8", 32'(q), 32'h8);
    check("dn_wrap8", 32'(wrap), 32'h0);
    step(0, 0, 1, 2'b11, 4'h0, 4'h0);
    check("dn_q7", 32'(q), 32'h7);

    // Toggle mode
    step(0, 1, 0, 2'b01, 4'h0, 4'b0101);
    step(0, 0, 1, 2'b01, 4'b0011, 4'h0);
    check("tog_q1", 32'(q), 32'b0110);
    check("tog_qn1", 32'(q_n), 32'b1001);
    step(0, 0, 1, 2'b01, 4'b0011, 4'h0);
    check("tog_q2", 32'(q), 32'b0101);
    check("tog_qn2", 32'(q_n), 32'b1010);

    // Out-of-range values
    step(0, 1, 0, 2'b10, 4'h0, 4'b1100);
    check("oor_tc_up", 32'(tc), 32'h1);
    step(0, 0, 1, 2'b10, 4'h0, 4'h0);
    check("oor_up_q", 32'(q), 32'h0);
    check("oor_up_wrap", 32'(wrap), 32'h1);
    step(0, 1, 0, 2'b11, 4'h0, 4'b1100);
    check("load_clears_wrap", 32'(wrap), 32'h0);
    step(0, 0, 1, 2'b11, 4'h0, 4'h0);
    check("oor_dn_q", 32'(q), 32'b1001);
    check("oor_dn_wrap", 32'(wrap), 32'h1);

    // Toggle ignores modulus: 9 ^ 0110 = 15
    step(0, 0, 1, 2'b01, 4'b0110, 4'h0);
    check("tog_beyond_mod", 32'(q), 32'hF);

    // Priority
    step(1, 1, 1, 2'b10, 4'h0, 4'b0111);
    check("prio_rst_load", 32'(q), 32'h0);
    step(0, 1, 1, 2'b10, 4'h0, 4'b0011);
    check("prio_load_en", 32'(q), 32'h3);
    check("prio_load_wrap", 32'(wrap), 32'h0);

    // Enable gating
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 2'b10, 4'hF, 4'h0);
      check("gate_q", 32'(q), 32'h3);
      check("gate_wrap", 32'(wrap), 32'h0);
    end
    step(0, 1, 0, 2'b10, 4'h0, 4'h9);
    step(0, 0, 0, 2'b10, 4'h0, 4'h0);
    check("gate_tc", 32'(tc), 32'h1);
    check("gate_q9", 32'(q), 32'h9);

    // Hold mode with en=1
    step(0, 0, 1, 2'b00, 4'hF, 4'h0);
    check("hold_q", 32'(q), 32'h9);
    check("hold_tc", 32'(tc), 32'h0);

    // Mid-count reset, then resume from 0
    step(0, 0, 1, 2'b10, 4'h0, 4'h0);
    step(0, 0, 1, 2'b10, 4'h0, 4'h0);
    check("mid_q1", 32'(q), 32'h1);
    step(1, 0, 1, 2'b10, 4'h0, 4'h0);
    step(0, 0, 1, 2'b10, 4'h0, 4'h0);
    check("resume_q", 32'(q), 32'h1);
    step(0, 0, 1, 2'b11, 4'h0, 4'h0);
    check("mode_switch_q", 32'(q), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
